// File: rtl/alu_cc_branch_unit.sv
// rtl/alu_cc_branch_unit.sv - banked condition-code store with PC/EXEC phase FSM and branch resolve
module alu_cc_branch_unit #(
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = 1,
  parameter int EXT_FLAGS = 0,
  parameter int COUNT_W   = 8
) (
  input  logic               clka,
  input  logic               reset_in,
  input  logic               stall_in,
  input  logic [BANK_W-1:0]  bank_sel_in,
  input  logic               we_reg_in,
  input  logic               n_alu_in,
  input  logic               z_alu_in,
  input  logic               p_alu_in,
  input  logic               c_alu_in,
  input  logic               v_alu_in,
  input  logic               n_dec_in,
  input  logic               z_dec_in,
  input  logic               p_dec_in,
  input  logic [1:0]         cv_dec_in,
  input  logic               br_in,
  output logic               pc_ctl_0_out,
  output logic               pc_latch_out,
  output logic [1:0]         state_out,
  output logic [4:0]         cc_out,
  output logic               flag_err_out,
  output logic [COUNT_W-1:0] taken_count_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PC   = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_nzp [NUM_BANKS];
  logic [1:0]         r_cv  [NUM_BANKS];
  logic               r_pc_ctl;
  logic               r_flag_err;
  logic [COUNT_W-1:0] r_count;

  logic       w_sel_ok;
  logic [2:0] w_bank_nzp;
  logic [1:0] w_bank_cv;
  logic [1:0] w_cv_eff;
  logic [2:0] w_nzp_alu;
  logic [2:0] w_nzp_dec;
  logic       w_onehot;
  logic       w_hit;
  logic       w_wr_try;
  logic       w_wr_ok;
  logic       w_take;

  // Out-of-range selects match no bank, so they read as zero and never write.
  always_comb begin
    w_sel_ok   = 1'b0;
    w_bank_nzp = 3'b000;
    w_bank_cv  = 2'b00;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_sel_in == BANK_W'(b)) begin
        w_sel_ok   = 1'b1;
        w_bank_nzp = r_nzp[b];
        w_bank_cv  = r_cv[b];
      end
    end
  end

  assign w_cv_eff  = (EXT_FLAGS != 0) ? w_bank_cv : 2'b00;
  assign w_nzp_alu = {n_alu_in, z_alu_in, p_alu_in};
  assign w_nzp_dec = {n_dec_in, z_dec_in, p_dec_in};
  assign w_onehot  = (w_nzp_alu == 3'b100) || (w_nzp_alu == 3'b010) || (w_nzp_alu == 3'b001);
  assign w_hit     = br_in & ((|(w_nzp_dec & w_bank_nzp)) | (|(cv_dec_in & w_cv_eff)));
  assign w_wr_try  = (r_state == S_EXEC) & ~stall_in & we_reg_in;
  assign w_wr_ok   = w_wr_try & w_onehot & w_sel_ok;
  assign w_take    = (r_state == S_PC) & ~stall_in & w_hit;

  always_ff @(posedge clka) begin
    if (reset_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Idle always leaves on the first free edge, even under stall.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_PC;
      S_PC:    if (!stall_in) w_state_nxt = S_EXEC;
      S_EXEC:  if (!stall_in) w_state_nxt = S_PC;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (reset_in) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_nzp[b] <= 3'b000;
        r_cv[b]  <= 2'b00;
      end
    end else if (w_wr_ok) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank_sel_in == BANK_W'(b)) begin
          r_nzp[b] <= w_nzp_alu;
          if (EXT_FLAGS != 0) r_cv[b] <= {c_alu_in, v_alu_in};
        end
      end
    end
  end

  always_ff @(posedge clka) begin
    if (reset_in) begin
      r_pc_ctl   <= 1'b0;
      r_flag_err <= 1'b0;
      r_count    <= '0;
    end else begin
      r_pc_ctl   <= w_take;
      r_flag_err <= w_wr_try & ~w_wr_ok;
      if (w_take && (r_count != {COUNT_W{1'b1}})) r_count <= r_count + COUNT_W'(1);
    end
  end

  assign pc_ctl_0_out    = r_pc_ctl;
  assign pc_latch_out    = (r_state == S_PC) & ~stall_in;
  assign state_out       = r_state;
  assign cc_out          = {w_bank_nzp, w_cv_eff};
  assign flag_err_out    = r_flag_err;
  assign taken_count_out = r_count;

endmodule

// File: tb/tb_alu_cc_branch_unit.sv
// tb/tb_alu_cc_branch_unit.sv - directed table plus randomized model check of alu_cc_branch_unit
module tb_alu_cc_branch_unit;

  logic       clka = 1'b0;
  logic       reset_in, stall_in, we_reg_in, br_in;
  logic [1:0] bank_sel_in, cv_dec_in;
  logic       n_alu_in, z_alu_in, p_alu_in, c_alu_in, v_alu_in;
  logic       n_dec_in, z_dec_in, p_dec_in;
  logic       pc_ctl_0_out, pc_latch_out, flag_err_out;
  logic [1:0] state_out, taken_count_out;
  logic [4:0] cc_out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clka = ~clka;

  alu_cc_branch_unit #(.NUM_BANKS(3), .BANK_W(2), .EXT_FLAGS(1), .COUNT_W(2)) dut (
    .clka(clka), .reset_in(reset_in), .stall_in(stall_in), .bank_sel_in(bank_sel_in),
    .we_reg_in(we_reg_in), .n_alu_in(n_alu_in), .z_alu_in(z_alu_in), .p_alu_in(p_alu_in),
    .c_alu_in(c_alu_in), .v_alu_in(v_alu_in), .n_dec_in(n_dec_in), .z_dec_in(z_dec_in),
    .p_dec_in(p_dec_in), .cv_dec_in(cv_dec_in), .br_in(br_in), .pc_ctl_0_out(pc_ctl_0_out),
    .pc_latch_out(pc_latch_out), .state_out(state_out), .cc_out(cc_out),
    .flag_err_out(flag_err_out), .taken_count_out(taken_count_out)
  );

  typedef struct {
    logic       rst, stall;
    logic [1:0] sel;
    logic       we;
    logic [4:0] alu;
    logic [4:0] dec;
    logic       br;
    logic [1:0] st;
    logic       latch, pc;
    logic [4:0] cc;
    logic       err;
    logic [1:0] cnt;
  } vec_t;

  function automatic vec_t v(input logic rst, input logic stall, input logic [1:0] sel,
                             input logic we, input logic [4:0] alu, input logic [4:0] dec,
                             input logic br, input logic [1:0] st, input logic latch,
                             input logic pc, input logic [4:0] cc, input logic err,
                             input logic [1:0] cnt);
    vec_t r;
    r.rst = rst; r.stall = stall; r.sel = sel; r.we = we; r.alu = alu; r.dec = dec; r.br = br;
    r.st = st; r.latch = latch; r.pc = pc; r.cc = cc; r.err = err; r.cnt = cnt;
    return r;
  endfunction

  task automatic drive(input logic rst, input logic stall, input logic [1:0] sel, input logic we,
                       input logic [4:0] alu, input logic [4:0] dec, input logic br);
    reset_in = rst; stall_in = stall; bank_sel_in = sel; we_reg_in = we;
    {n_alu_in, z_alu_in, p_alu_in, c_alu_in, v_alu_in} = alu;
    {n_dec_in, z_dec_in, p_dec_in, cv_dec_in} = dec;
    br_in = br;
  endtask

  task automatic check(input string name, input int idx, input logic [1:0] st, input logic latch,
                       input logic pc, input logic [4:0] cc, input logic err, input logic [1:0] cnt);
    n_vec++;
    if (state_out !== st || pc_latch_out !== latch || pc_ctl_0_out !== pc || cc_out !== cc ||
        flag_err_out !== err || taken_count_out !== cnt) begin
      n_bad++;
      $display("FAIL %s[%0d]: got st=%0d latch=%0b pc=%0b cc=%b err=%0b cnt=%0d, want st=%0d latch=%0b pc=%0b cc=%b err=%0b cnt=%0d",
               name, idx, state_out, pc_latch_out, pc_ctl_0_out, cc_out, flag_err_out,
               taken_count_out, st, latch, pc, cc, err, cnt);
    end
  endtask

  // Reference model: phase number, per-bank 5-bit flag words, plain saturating integer count.
  int         m_phase;
  logic [4:0] m_bank [3];
  logic       m_pc, m_err;
  int         m_cnt;

  function automatic logic [4:0] m_read(input logic [1:0] sel);
    return (sel < 2'd3) ? m_bank[sel] : 5'b0;
  endfunction

  task automatic m_step(input logic rst, input logic stall, input logic [1:0] sel, input logic we,
                        input logic [4:0] alu, input logic [4:0] dec, input logic br);
    logic [4:0] bk;
    logic       hit;
    if (rst) begin
      m_phase = 0; m_pc = 0; m_err = 0; m_cnt = 0;
      for (int i = 0; i < 3; i++) m_bank[i] = 5'b0;
      return;
    end
    bk  = m_read(sel);
    hit = br && ((dec & bk) != 5'b0);
    m_pc  = (m_phase == 1) && !stall && hit;
    m_err = 0;
    if (m_pc) m_cnt = (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
    if (m_phase == 2 && !stall && we) begin
      if ($countones(alu[4:2]) == 1 && sel < 2'd3) m_bank[sel] = alu;
      else m_err = 1;
    end
    if (m_phase == 0) m_phase = 1;
    else if (!stall) m_phase = 3 - m_phase;
  endtask

  vec_t tbl[36];

  initial begin
    tbl[0]  = v(1,0,0,0,5'b00000,5'b00000,0, 0,0,0,5'b00000,0,0);
    tbl[1]  = v(1,0,0,0,5'b00000,5'b00000,0, 0,0,0,5'b00000,0,0);
    tbl[2]  = v(0,0,0,0,5'b00000,5'b00000,0, 0,0,0,5'b00000,0,0);
    tbl[3]  = v(0,0,0,0,5'b00000,5'b11100,1, 1,1,0,5'b00000,0,0);
    tbl[4]  = v(0,0,0,0,5'b00000,5'b11100,1, 2,0,0,5'b00000,0,0);
    tbl[5]  = v(0,0,0,0,5'b00000,5'b11100,1, 1,1,0,5'b00000,0,0);
    tbl[6]  = v(0,0,0,0,5'b00000,5'b11100,1, 2,0,0,5'b00000,0,0);
    tbl[7]  = v(0,0,0,1,5'b01000,5'b00000,0, 1,1,0,5'b00000,0,0);
    tbl[8]  = v(0,0,1,1,5'b10000,5'b00000,0, 2,0,0,5'b00000,0,0);
    tbl[9]  = v(0,0,1,0,5'b00000,5'b00000,0, 1,1,0,5'b10000,0,0);
    tbl[10] = v(0,0,0,1,5'b11000,5'b00000,0, 2,0,0,5'b00000,0,0);
    tbl[11] = v(0,0,0,0,5'b00000,5'b00000,0, 1,1,0,5'b00000,1,0);
    tbl[12] = v(0,0,0,1,5'b01000,5'b00000,0, 2,0,0,5'b00000,0,0);
    tbl[13] = v(0,0,0,0,5'b00000,5'b01000,1, 1,1,0,5'b01000,0,0);
    tbl[14] = v(0,0,0,0,5'b00000,5'b00000,0, 2,0,1,5'b01000,0,1);
    tbl[15] = v(0,0,0,0,5'b00000,5'b10000,1, 1,1,0,5'b01000,0,1);
    tbl[16] = v(0,0,0,0,5'b00000,5'b00000,0, 2,0,0,5'b01000,0,1);
    tbl[17] = v(0,0,0,0,5'b00000,5'b01000,0, 1,1,0,5'b01000,0,1);
    tbl[18] = v(0,0,0,0,5'b00000,5'b00000,0, 2,0,0,5'b01000,0,1);
    tbl[19] = v(0,1,0,1,5'b10000,5'b00000,0, 1,0,0,5'b01000,0,1);
    tbl[20] = v(0,1,0,1,5'b10000,5'b00000,0, 1,0,0,5'b01000,0,1);
    tbl[21] = v(0,0,0,0,5'b00000,5'b00000,0, 1,1,0,5'b01000,0,1);
    tbl[22] = v(0,1,0,1,5'b10000,5'b00000,0, 2,0,0,5'b01000,0,1);
    tbl[23] = v(0,0,2,1,5'b00110,5'b00000,0, 2,0,0,5'b00000,0,1);
    tbl[24] = v(0,0,2,0,5'b00000,5'b00010,1, 1,1,0,5'b00110,0,1);
    tbl[25] = v(0,0,2,0,5'b00000,5'b00000,0, 2,0,1,5'b00110,0,2);
    tbl[26] = v(0,0,2,0,5'b00000,5'b00010,1, 1,1,0,5'b00110,0,2);
    tbl[27] = v(0,0,2,0,5'b00000,5'b00000,0, 2,0,1,5'b00110,0,3);
    tbl[28] = v(0,0,2,0,5'b00000,5'b00010,1, 1,1,0,5'b00110,0,3);
    tbl[29] = v(0,0,2,0,5'b00000,5'b00000,0, 2,0,1,5'b00110,0,3);
    tbl[30] = v(0,0,3,0,5'b00000,5'b11111,1, 1,1,0,5'b00000,0,3);
    tbl[31] = v(0,0,3,1,5'b10000,5'b00000,0, 2,0,0,5'b00000,0,3);
    tbl[32] = v(0,0,0,0,5'b00000,5'b00000,0, 1,1,0,5'b01000,1,3);
    tbl[33] = v(1,1,0,0,5'b00000,5'b00000,0, 2,0,0,5'b01000,0,3);
    tbl[34] = v(0,1,0,0,5'b00000,5'b00000,0, 0,0,0,5'b00000,0,0);
    tbl[35] = v(0,0,0,0,5'b00000,5'b00000,0, 1,1,0,5'b00000,0,0);

    drive(1, 0, 0, 0, 5'b0, 5'b0, 0);
    @(posedge clka); #1;

    for (int i = 0; i < 36; i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].sel, tbl[i].we, tbl[i].alu, tbl[i].dec, tbl[i].br);
      #3;
      check("dir", i, tbl[i].st, tbl[i].latch, tbl[i].pc, tbl[i].cc, tbl[i].err, tbl[i].cnt);
      @(posedge clka); #1;
    end

    drive(1, 0, 0, 0, 5'b0, 5'b0, 0);
    m_step(1, 0, 0, 0, 5'b0, 5'b0, 0);
    @(posedge clka); #1;

    for (int i = 0; i < 600; i++) begin
      logic       r_rst, r_stall, r_we, r_br;
      logic [1:0] r_sel;
      logic [4:0] r_alu, r_dec;
      r_rst   = ($urandom_range(0, 79) == 0);
      r_stall = ($urandom_range(0, 3) == 0);
      r_sel   = 2'($urandom_range(0, 3));
      r_we    = $urandom_range(0, 1) == 1;
      r_alu   = 5'($urandom);
      if ($urandom_range(0, 2) != 0) r_alu[4:2] = 3'b001 << $urandom_range(0, 2);
      r_dec   = 5'($urandom);
      r_br    = $urandom_range(0, 2) != 0;
      drive(r_rst, r_stall, r_sel, r_we, r_alu, r_dec, r_br);
      #3;
      check("rnd", i, 2'(m_phase), (m_phase == 1) && !r_stall, m_pc, m_read(r_sel), m_err, 2'(m_cnt));
      m_step(r_rst, r_stall, r_sel, r_we, r_alu, r_dec, r_br);
      @(posedge clka); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
